// File: rtl/ts_pid_demux_if.sv
// ts_pid_demux_if
// Byte-stream bundle around the PID demultiplexer.
//   in_data / in_valid / in_ready : upstream transport-stream byte handshake
//   out_data                      : routed byte (shared by all channels)
//   out_valid                     : one-hot channel strobe, 0 when idle
//   out_sop / out_eop             : first / last byte of a routed packet
// The slave modport is the demultiplexer side; the master modport is the
// side that sources bytes and consumes the channel outputs.
interface ts_pid_demux_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [3:0]            out_valid;
  logic                  out_sop;
  logic                  out_eop;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop
  );
endinterface

// File: rtl/ts_pid_demux.sv
// ts_pid_demux
// Routes 188-byte MPEG-2 transport stream packets to one of four channels by
// PID. Sync is acquired on SYNC_BYTE, the 4-byte header is captured, and the
// 13-bit PID is matched against four programmable slots (lowest enabled
// matching slot wins). Routed packets replay the buffered header during a
// 4-cycle input stall, then stream the body with one cycle of latency.
// Packets with TEI set or no matching slot are consumed silently and counted.
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : input byte handshake and registered channel outputs
//   pid_0_i..3_i   : PID per channel, sampled when header byte 3 is accepted
//   pid_en_i       : per-channel match enable
//   sync_err_o     : one-cycle pulse when an expected sync byte is missing
//   drop_cnt_o     : saturating count of dropped packets
module ts_pid_demux #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47
) (
  input  logic                clk,
  input  logic                rst,
  ts_pid_demux_if.slave       bus,
  input  logic [12:0]         pid_0_i,
  input  logic [12:0]         pid_1_i,
  input  logic [12:0]         pid_2_i,
  input  logic [12:0]         pid_3_i,
  input  logic [3:0]          pid_en_i,
  output logic                sync_err_o,
  output logic [15:0]         drop_cnt_o
);

  localparam int IDX_W = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    HUNT,
    HDR,
    EMIT,
    BODY
  } state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [1:0]                     emit_q, emit_d;
  logic [3:0][DATA_WIDTH-1:0]     hdr_q, hdr_d;
  logic [3:0]                     sel_q, sel_d;
  logic                           drop_q, drop_d;
  logic [15:0]                    dropCnt_q, dropCnt_d;
  logic [DATA_WIDTH-1:0]          outData_q, outData_d;
  logic [3:0]                     outValid_q, outValid_d;
  logic                           outSop_q, outSop_d;
  logic                           outEop_q, outEop_d;
  logic                           syncErr_q, syncErr_d;

  logic                           inReady;
  logic                           accept;
  logic [12:0]                    pidSlot [4];
  logic [12:0]                    pktPid;
  logic                           pktTei;
  logic [3:0]                     matchSel;
  logic                           isSync;

  assign inReady = (state_q != EMIT);
  assign accept  = bus.in_valid && inReady;
  assign isSync  = (bus.in_data == SYNC_BYTE);

  assign pidSlot[0] = pid_0_i;
  assign pidSlot[1] = pid_1_i;
  assign pidSlot[2] = pid_2_i;
  assign pidSlot[3] = pid_3_i;

  // Header bytes 1 and 2 are already registered when byte 3 arrives.
  assign pktPid = {hdr_q[1][4:0], hdr_q[2]};
  assign pktTei = hdr_q[1][7];

  // Scanning from the top down lets the lowest matching slot overwrite.
  always_comb begin
    matchSel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pid_en_i[i] && (pidSlot[i] == pktPid)) begin
        matchSel    = '0;
        matchSel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      emit_q     <= '0;
      hdr_q      <= '0;
      sel_q      <= '0;
      drop_q     <= 1'b0;
      dropCnt_q  <= '0;
      outData_q  <= '0;
      outValid_q <= '0;
      outSop_q   <= 1'b0;
      outEop_q   <= 1'b0;
      syncErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      emit_q     <= emit_d;
      hdr_q      <= hdr_d;
      sel_q      <= sel_d;
      drop_q     <= drop_d;
      dropCnt_q  <= dropCnt_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outSop_q   <= outSop_d;
      outEop_q   <= outEop_d;
      syncErr_q  <= syncErr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    emit_d    = emit_q;
    hdr_d     = hdr_q;
    sel_d     = sel_q;
    drop_d    = drop_q;
    dropCnt_d = dropCnt_q;
    case (state_q)
      HUNT: begin
        if (accept && isSync) begin
          hdr_d[0] = bus.in_data;
          idx_d    = IDX_W'(1);
          state_d  = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          if (idx_q == '0) begin
            if (isSync) begin
              hdr_d[0] = bus.in_data;
              idx_d    = IDX_W'(1);
            end else begin
              state_d = HUNT;
            end
          end else begin
            hdr_d[idx_q[1:0]] = bus.in_data;
            idx_d             = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(3)) begin
              if (pktTei || (matchSel == '0)) begin
                drop_d  = 1'b1;
                sel_d   = '0;
                state_d = BODY;
                if (dropCnt_q != 16'hFFFF) begin
                  dropCnt_d = dropCnt_q + 16'd1;
                end
              end else begin
                drop_d  = 1'b0;
                sel_d   = matchSel;
                emit_d  = '0;
                state_d = EMIT;
              end
            end
          end
        end
      end
      EMIT: begin
        emit_d = emit_q + 2'd1;
        if (emit_q == 2'd3) begin
          state_d = BODY;
        end
      end
      BODY: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = HDR;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Outputs are zero unless this edge carries a replayed header byte or an
  // accepted body byte; sel_q is already zero for dropped packets.
  always_comb begin
    outData_d  = '0;
    outValid_d = '0;
    outSop_d   = 1'b0;
    outEop_d   = 1'b0;
    syncErr_d  = 1'b0;
    case (state_q)
      HDR: begin
        if (accept && (idx_q == '0) && !isSync) begin
          syncErr_d = 1'b1;
        end
      end
      EMIT: begin
        outData_d  = hdr_q[emit_q];
        outValid_d = sel_q;
        outSop_d   = (emit_q == 2'd0);
      end
      BODY: begin
        if (accept) begin
          outData_d  = bus.in_data;
          outValid_d = sel_q;
          outEop_d   = !drop_q && (idx_q == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = inReady;
  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_sop   = outSop_q;
  assign bus.out_eop   = outEop_q;
  assign sync_err_o    = syncErr_q;
  assign drop_cnt_o    = dropCnt_q;

endmodule

// File: tb/tb_ts_pid_demux.sv
// tb_ts_pid_demux
// Directed bench for ts_pid_demux: builds transport stream packets, drives
// them through the byte handshake (continuous or throttled), collects the
// channel beats and compares them with the beats expected for each packet.
module tb_ts_pid_demux;

  logic        clk;
  logic        rst;
  logic [12:0] pid0, pid1, pid2, pid3;
  logic [3:0]  pidEn;
  logic        syncErr;
  logic [15:0] dropCnt;

  int assertCount = 0;
  int failCount   = 0;

  // Beat word: {out_valid[3:0], out_sop, out_eop, out_data[7:0]}
  logic [7:0]  txQ [$];
  logic [13:0] expQ [$];
  logic [13:0] rxQ [$];

  int readyLow   = 0;
  int syncErrCnt = 0;
  int eopSeen    = 0;
  bit prevAccept = 1'b0;
  bit prevReady  = 1'b1;

  ts_pid_demux_if #(.DATA_WIDTH(8)) bus ();

  ts_pid_demux dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pid_0_i    (pid0),
    .pid_1_i    (pid1),
    .pid_2_i    (pid2),
    .pid_3_i    (pid3),
    .pid_en_i   (pidEn),
    .sync_err_o (syncErr),
    .drop_cnt_o (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Beats are legal only after an accepted byte or during the header replay.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid != 4'b0) begin
        rxQ.push_back({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data});
        checkOutput("beatSource", {31'b0, prevAccept || !prevReady}, 32'd1);
      end
      if (!bus.in_ready) readyLow++;
      if (syncErr) syncErrCnt++;
      if (bus.out_eop) eopSeen++;
    end
    prevAccept = bus.in_valid && bus.in_ready;
    prevReady  = bus.in_ready;
  end

  task automatic buildPacket(input logic [12:0] pid, input bit tei,
                             input logic [3:0] expCh, input int nBytes);
    logic [7:0] b;
    for (int i = 0; i < nBytes; i++) begin
      case (i)
        0:       b = 8'h47;
        1:       b = {tei, 2'b00, pid[12:8]};
        2:       b = pid[7:0];
        3:       b = 8'h10;
        default: b = 8'(i);
      endcase
      txQ.push_back(b);
      if (expCh != 4'b0) begin
        expQ.push_back({expCh, (i == 0), (i == 187), b});
      end
    end
  endtask

  task automatic applyStimulus(input bit throttle);
    bit took    = 1'b0;
    bit stalled = 1'b0;
    int cycles  = 0;
    while (txQ.size() > 0) begin
      @(posedge clk);
      #1;
      if (took) void'(txQ.pop_front());
      if (txQ.size() == 0) break;
      if (stalled || !throttle) bus.in_valid = 1'b1;
      else bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = txQ[0];
      @(negedge clk);
      took    = bus.in_valid && bus.in_ready;
      stalled = bus.in_valid && !bus.in_ready;
      cycles++;
      if (cycles > 5000) begin
        checkOutput("stimTimeout", cycles, 0);
        txQ.delete();
      end
    end
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    rxQ.delete();
    expQ.delete();
    readyLow   = 0;
    syncErrCnt = 0;
    eopSeen    = 0;
  endtask

  task automatic compareBeats(input string tag);
    int n;
    checkOutput({tag, "Count"}, rxQ.size(), expQ.size());
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      if (rxQ[i] !== expQ[i]) begin
        checkOutput({tag, "Beat"}, {18'b0, rxQ[i]}, {18'b0, expQ[i]});
        break;
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    pid0         = 13'h000;
    pid1         = 13'h050;
    pid2         = 13'h100;
    pid3         = 13'h000;
    pidEn        = 4'b0100;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstInReady",  {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rstOutData",  {24'b0, bus.out_data}, 32'd0);
    checkOutput("rstOutValid", {28'b0, bus.out_valid}, 32'd0);
    checkOutput("rstSop",      {31'b0, bus.out_sop}, 32'd0);
    checkOutput("rstEop",      {31'b0, bus.out_eop}, 32'd0);
    checkOutput("rstSyncErr",  {31'b0, syncErr}, 32'd0);
    checkOutput("rstDropCnt",  {16'b0, dropCnt}, 32'd0);
    rst = 1'b0;

    // Routed packet, continuous input, channel 2
    clearLogs();
    buildPacket(13'h100, 1'b0, 4'b0100, 188);
    applyStimulus(1'b0);
    compareBeats("routed");
    checkOutput("routedStall", readyLow, 4);
    checkOutput("routedEop", eopSeen, 1);

    // Unmatched PID is dropped
    clearLogs();
    buildPacket(13'h0AB, 1'b0, 4'b0000, 188);
    applyStimulus(1'b0);
    compareBeats("dropNoMatch");
    checkOutput("dropNoMatchCnt", {16'b0, dropCnt}, 32'd1);
    checkOutput("dropNoStall", readyLow, 0);

    // Matching PID but TEI set is dropped
    clearLogs();
    buildPacket(13'h100, 1'b1, 4'b0000, 188);
    applyStimulus(1'b0);
    compareBeats("dropTei");
    checkOutput("dropTeiCnt", {16'b0, dropCnt}, 32'd2);

    // Priority: slots 0 and 3 share a PID
    pid0  = 13'h200;
    pid3  = 13'h200;
    pidEn = 4'hF;
    clearLogs();
    buildPacket(13'h200, 1'b0, 4'b0001, 188);
    applyStimulus(1'b0);
    compareBeats("prioLow");
    pidEn = 4'b1110;
    clearLogs();
    buildPacket(13'h200, 1'b0, 4'b1000, 188);
    applyStimulus(1'b0);
    compareBeats("prioHigh");
    checkOutput("prioDropCnt", {16'b0, dropCnt}, 32'd2);

    // Sync loss between packets, then reacquisition
    pidEn = 4'b0100;
    clearLogs();
    buildPacket(13'h100, 1'b0, 4'b0100, 188);
    txQ.push_back(8'h12);
    txQ.push_back(8'h00);
    txQ.push_back(8'h33);
    txQ.push_back(8'hAA);
    buildPacket(13'h100, 1'b0, 4'b0100, 188);
    applyStimulus(1'b0);
    compareBeats("syncLoss");
    checkOutput("syncErrPulse", syncErrCnt, 1);
    checkOutput("syncLossStall", readyLow, 8);

    // Three back-to-back packets with throttled input
    clearLogs();
    for (int p = 0; p < 3; p++) buildPacket(13'h100, 1'b0, 4'b0100, 188);
    applyStimulus(1'b1);
    compareBeats("throttle");
    checkOutput("throttleBeats", rxQ.size(), 564);
    checkOutput("throttleEop", eopSeen, 3);

    // Reset in the middle of a packet abandons it without an end-of-packet
    clearLogs();
    buildPacket(13'h100, 1'b0, 4'b0100, 100);
    applyStimulus(1'b0);
    compareBeats("partial");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstDropCnt",  {16'b0, dropCnt}, 32'd0);
    checkOutput("midRstOutValid", {28'b0, bus.out_valid}, 32'd0);
    checkOutput("midRstEop", eopSeen, 0);
    rst = 1'b0;

    // The block hunts for sync again after reset
    clearLogs();
    buildPacket(13'h100, 1'b0, 4'b0100, 188);
    applyStimulus(1'b0);
    compareBeats("afterRst");
    checkOutput("afterRstSync", syncErrCnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
